// File: rtl/board_win_scanner.sv
// Sequential four-in-a-row detector for the 4x4 board: snapshots the board on start,
// evaluates one of the 10 candidate lines per clock and reports winner/line/draw.
module board_win_scanner #(
  parameter int EARLY_EXIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] gameboard,
  input  logic [15:0] players_cells,
  output logic        busy,
  output logic        done,
  output logic        win_valid,
  output logic        winner,
  output logic [3:0]  win_line,
  output logic        draw
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;
  localparam logic [3:0] LAST_LINE = 4'd9;

  logic [1:0]  state_q, state_d;
  logic [3:0]  line_q, line_d;
  logic [15:0] gb_q, gb_d;
  logic [15:0] pc_q, pc_d;
  logic        win_valid_q, win_valid_d;
  logic        winner_q, winner_d;
  logic [3:0]  win_line_q, win_line_d;
  logic        draw_q, draw_d;

  logic [15:0] line_mask;
  logic [15:0] line_owners;
  logic        line_win;
  logic        line_owner;

  // Cell set of the line under evaluation; cell index = row*4 + col.
  always_comb begin
    line_mask = 16'h0000;
    case (line_q)
      4'd0: line_mask = 16'h000F;
      4'd1: line_mask = 16'h00F0;
      4'd2: line_mask = 16'h0F00;
      4'd3: line_mask = 16'hF000;
      4'd4: line_mask = 16'h1111;
      4'd5: line_mask = 16'h2222;
      4'd6: line_mask = 16'h4444;
      4'd7: line_mask = 16'h8888;
      4'd8: line_mask = 16'h8421;
      4'd9: line_mask = 16'h1248;
      default: line_mask = 16'h0000;
    endcase
  end

  // Owner bits only matter once every cell of the line is occupied.
  assign line_owners = pc_q & line_mask;
  assign line_win    = (line_mask != 16'h0000) && ((gb_q & line_mask) == line_mask) &&
                       ((line_owners == line_mask) || (line_owners == 16'h0000));
  assign line_owner  = |line_owners;

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    gb_d        = gb_q;
    pc_d        = pc_q;
    win_valid_d = win_valid_q;
    winner_d    = winner_q;
    win_line_d  = win_line_q;
    draw_d      = draw_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SCAN;
          line_d      = 4'd0;
          gb_d        = gameboard;
          pc_d        = players_cells;
          win_valid_d = 1'b0;
          winner_d    = 1'b0;
          win_line_d  = 4'd0;
          draw_d      = 1'b0;
        end
      end
      S_SCAN: begin
        if (line_win && !win_valid_q) begin
          win_valid_d = 1'b1;
          winner_d    = line_owner;
          win_line_d  = line_q;
        end
        if ((win_valid_d && (EARLY_EXIT != 0)) || (line_q == LAST_LINE)) begin
          state_d = S_REPORT;
          draw_d  = (gb_q == 16'hFFFF) && !win_valid_d;
        end else begin
          line_d = line_q + 4'd1;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      line_q      <= 4'd0;
      gb_q        <= 16'h0000;
      pc_q        <= 16'h0000;
      win_valid_q <= 1'b0;
      winner_q    <= 1'b0;
      win_line_q  <= 4'd0;
      draw_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      gb_q        <= gb_d;
      pc_q        <= pc_d;
      win_valid_q <= win_valid_d;
      winner_q    <= winner_d;
      win_line_q  <= win_line_d;
      draw_q      <= draw_d;
    end
  end

  assign busy      = (state_q == S_SCAN);
  assign done      = (state_q == S_REPORT);
  assign win_valid = win_valid_q;
  assign winner    = winner_q;
  assign win_line  = win_line_q;
  assign draw      = draw_q;

endmodule

// File: tb/tb_board_win_scanner.sv
// Directed bench: two scanners (early exit on/off) share stimulus; results and done latency
// are compared against hand-computed vectors plus snapshot, busy and reset sequences.
module tb_board_win_scanner;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] gameboard;
  logic [15:0] players_cells;

  logic       busy1, done1, valid1, winner1, draw1;
  logic [3:0] line1;
  logic       busy0, done0, valid0, winner0, draw0;
  logic [3:0] line0;

  int total_checks;
  int passed_checks;

  board_win_scanner #(.EARLY_EXIT(1)) dut_ee1 (
    .clk(clk), .reset_n(reset_n), .start(start), .gameboard(gameboard),
    .players_cells(players_cells), .busy(busy1), .done(done1), .win_valid(valid1),
    .winner(winner1), .win_line(line1), .draw(draw1)
  );

  board_win_scanner #(.EARLY_EXIT(0)) dut_ee0 (
    .clk(clk), .reset_n(reset_n), .start(start), .gameboard(gameboard),
    .players_cells(players_cells), .busy(busy0), .done(done0), .win_valid(valid0),
    .winner(winner0), .win_line(line0), .draw(draw0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] gb;
    logic [15:0] pc;
    logic        valid;
    logic        winner;
    logic [3:0]  line;
    logic        draw;
    int          lat1;
    int          lat0;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    total_checks++;
    if (act == exp) passed_checks++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drives one scan; latency = n where done is seen in the cycle after edge E_n.
  task automatic run_scan(input logic [15:0] gb, input logic [15:0] pc,
                          input bit clear_mid, input bit restart_mid,
                          output int lat1, output int lat0,
                          output int pulses1, output int pulses0,
                          output int busy_ok);
    lat1 = -1; lat0 = -1; pulses1 = 0; pulses0 = 0; busy_ok = 1;
    @(negedge clk);
    gameboard = gb; players_cells = pc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (!(busy1 && busy0)) busy_ok = 0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done1) begin pulses1++; if (lat1 < 0) lat1 = n; if (busy1) busy_ok = 0; end
      if (done0) begin pulses0++; if (lat0 < 0) lat0 = n; if (busy0) busy_ok = 0; end
      if (clear_mid && n == 1) gameboard = 16'h0000;
      start = (restart_mid && n == 3);
    end
    start = 1'b0;
  endtask

  task automatic check_results(input string tag, input vec_t v, input int l1, input int l0,
                               input int p1, input int p0, input int bok);
    chk({tag, " ee1 win_valid"}, valid1, v.valid);
    chk({tag, " ee1 winner"}, winner1, v.winner);
    chk({tag, " ee1 win_line"}, line1, v.line);
    chk({tag, " ee1 draw"}, draw1, v.draw);
    chk({tag, " ee1 latency"}, l1, v.lat1);
    chk({tag, " ee1 done pulses"}, p1, 1);
    chk({tag, " ee0 win_valid"}, valid0, v.valid);
    chk({tag, " ee0 winner"}, winner0, v.winner);
    chk({tag, " ee0 win_line"}, line0, v.line);
    chk({tag, " ee0 draw"}, draw0, v.draw);
    chk({tag, " ee0 latency"}, l0, v.lat0);
    chk({tag, " ee0 done pulses"}, p0, 1);
    chk({tag, " busy"}, bok, 1);
  endtask

  initial begin
    int l1, l0, p1, p0, bok;
    vec_t v;
    total_checks = 0;
    passed_checks = 0;

    vecs[0] = '{"row0_p1",      16'h000F, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 1, 10};
    vecs[1] = '{"col2_p2",      16'h4444, 16'h4444, 1'b1, 1'b1, 4'd6, 1'b0, 7, 10};
    vecs[2] = '{"anti_mixed",   16'h1248, 16'h1240, 1'b0, 1'b0, 4'd0, 1'b0, 10, 10};
    vecs[3] = '{"anti_p2",      16'h1248, 16'h1248, 1'b1, 1'b1, 4'd9, 1'b0, 10, 10};
    vecs[4] = '{"full_draw",    16'hFFFF, 16'h3C3C, 1'b0, 1'b0, 4'd0, 1'b1, 10, 10};
    vecs[5] = '{"garbage_pc",   16'h000F, 16'hFFF0, 1'b1, 1'b0, 4'd0, 1'b0, 1, 10};
    vecs[6] = '{"both_players", 16'hFFFF, 16'h00FF, 1'b1, 1'b1, 4'd0, 1'b0, 1, 10};
    vecs[7] = '{"diag_p1",      16'h8421, 16'h0000, 1'b1, 1'b0, 4'd8, 1'b0, 9, 10};
    vecs[8] = '{"col3_p1",      16'h8888, 16'h7777, 1'b1, 1'b0, 4'd7, 1'b0, 8, 10};
    vecs[9] = '{"empty",        16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b0, 10, 10};

    reset_n = 1'b0; start = 1'b0; gameboard = '0; players_cells = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs ee1", {busy1, done1, valid1, winner1, line1, draw1}, 0);
    chk("reset outputs ee0", {busy0, done0, valid0, winner0, line0, draw0}, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_scan(vecs[i].gb, vecs[i].pc, 1'b0, 1'b0, l1, l0, p1, p0, bok);
      check_results(vecs[i].name, vecs[i], l1, l0, p1, p0, bok);
      $display("vector %s gb=%h pc=%h -> ee1 v=%0d w=%0d l=%0d d=%0d lat=%0d | ee0 lat=%0d",
               vecs[i].name, vecs[i].gb, vecs[i].pc, valid1, winner1, line1, draw1, l1, l0);
    end

    // Board cleared after the accepting edge must not disturb the snapshot.
    run_scan(16'h000F, 16'h0000, 1'b1, 1'b0, l1, l0, p1, p0, bok);
    check_results("snapshot", vecs[0], l1, l0, p1, p0, bok);
    $display("sequence snapshot -> ee1 v=%0d l=%0d ee0 v=%0d l=%0d", valid1, line1, valid0, line0);

    // A second start mid-scan is dropped: one pulse each, latency unchanged.
    run_scan(16'h4444, 16'h4444, 1'b0, 1'b1, l1, l0, p1, p0, bok);
    check_results("restart_ignored", vecs[1], l1, l0, p1, p0, bok);
    $display("sequence restart_ignored -> pulses ee1=%0d ee0=%0d", p1, p0);

    // Asynchronous reset at E4 of a scan aborts it with no done pulse.
    @(negedge clk);
    gameboard = 16'h000F; players_cells = 16'h0000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort outputs ee1", {busy1, done1, valid1, winner1, line1, draw1}, 0);
    chk("abort outputs ee0", {busy0, done0, valid0, winner0, line0, draw0}, 0);
    p0 = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done0 || done1) p0++;
      if (n == 3) reset_n = 1'b1;
    end
    chk("abort no done", p0, 0);
    $display("sequence reset_abort -> done pulses after abort=%0d", p0);

    v = vecs[1];
    run_scan(v.gb, v.pc, 1'b0, 1'b0, l1, l0, p1, p0, bok);
    check_results("after_reset", v, l1, l0, p1, p0, bok);
    $display("sequence after_reset -> ee1 w=%0d l=%0d lat=%0d", winner1, line1, l1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
